// File: rtl/unary_stream_counter.sv
// Counts ones over a LENGTH-bit unary stream; UNARY_BOUNDS_OUT_EN adds progressive lower/upper bounds.
// Latency: out_valid rises 1 cycle after the LENGTH-th accepted bit; all outputs registered or state-decoded.
// Backpressure: result held in HOLD (in_ready=0) until out_ready; start with out_ready chains streams.
module unary_stream_counter #(
    parameter int LENGTH      = 32,
    parameter int COUNT_WIDTH = $clog2(LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_bit,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] out_value,
    output logic                   busy
`ifdef UNARY_BOUNDS_OUT_EN
    ,
    output logic [COUNT_WIDTH-1:0] lower_bound,
    output logic [COUNT_WIDTH-1:0] upper_bound
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LEN_C  = COUNT_WIDTH'(LENGTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_C = COUNT_WIDTH'(LENGTH - 1);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [COUNT_WIDTH-1:0] ones_cnt_q, ones_cnt_d;
    logic [COUNT_WIDTH-1:0] value_q, value_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        value_d    = value_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                // start aborts the stream and wins over a same-cycle data bit
                if (start) begin
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                end else if (in_valid) begin
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    ones_cnt_d = ones_cnt_q + COUNT_WIDTH'(in_bit);
                    if (bit_cnt_q == LAST_C) begin
                        value_d = ones_cnt_q + COUNT_WIDTH'(in_bit);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        bit_cnt_d  = '0;
                        ones_cnt_d = '0;
                        state_d    = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
            value_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            value_q    <= value_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign busy      = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_value = value_q;

`ifdef UNARY_BOUNDS_OUT_EN
    logic [COUNT_WIDTH-1:0] lower_q, lower_d;
    logic [COUNT_WIDTH-1:0] upper_q, upper_d;

    // Counters saturate at LENGTH on completion, so both bounds collapse onto the result in HOLD.
    always_comb begin
        lower_d = ones_cnt_d;
        upper_d = ones_cnt_d + (LEN_C - bit_cnt_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lower_q <= '0;
            upper_q <= LEN_C;
        end else begin
            lower_q <= lower_d;
            upper_q <= upper_d;
        end
    end

    assign lower_bound = lower_q;
    assign upper_bound = upper_q;
`endif

endmodule

// File: doc/unary_stream_counter.md
Name: unary_stream_counter

Overview:
- Downstream stage of the unary arithmetic units. Consumes one unary result bit per valid cycle (e.g. a multiplier's y/valid) and counts ones over a fixed stream length LENGTH.
- Presents the binary count on a ready/valid output handshake.
- Converts unary-domain results back to binary for checking and readout.
- Optional progressive lower/upper bound outputs expose the partial result before the stream completes.

Parameters:
- LENGTH, 32: unary stream length (bits per result); must be >= 1.
- COUNT_WIDTH, $clog2(LENGTH+1): width of all count outputs; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new collection (clears counters).
- in_bit  input  1  unary data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle (high only in COLLECT).
- out_valid  output  1  out_value holds a completed result.
- out_ready  input  1  consumer takes out_value.
- out_value  output  COUNT_WIDTH  number of ones in the completed stream, 0..LENGTH.
- busy  output  1  high in COLLECT.
- lower_bound  output  COUNT_WIDTH  (UNARY_BOUNDS_OUT_EN only) ones so far.
- upper_bound  output  COUNT_WIDTH  (UNARY_BOUNDS_OUT_EN only) ones so far plus bits remaining.

Behaviour:
- Reset (sampled at clk edge while reset=1):
  - state=IDLE.
  - bit_count=0, ones_count=0, out_value=0.
  - out_valid=0, busy=0.
  - Reset mid-stream discards the partial result with no output.
- States IDLE, COLLECT, HOLD. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=0; in_valid ignored.
  - start=1: counters cleared, state -> COLLECT next cycle.
- COLLECT:
  - in_ready=1, busy=1.
  - Each cycle with in_valid=1: bit_count+=1, ones_count+=in_bit.
  - in_valid=0 cycles (gaps) change nothing.
  - When the accepted bit is the LENGTH-th:
    - out_value <= ones_count + in_bit.
    - state -> HOLD.
    - out_valid=1 on the next cycle, i.e. 1-cycle latency from the last accepted bit.
  - start=1 while in COLLECT aborts the stream: counters cleared, state stays COLLECT, that cycle's in_bit is discarded. start has priority over in_valid.
- HOLD:
  - out_valid=1; out_value stable; in_ready=0; in_valid ignored; start ignored unless out_ready=1.
  - out_ready=1: result consumed.
    - With start=1 in the same cycle: counters cleared, state -> COLLECT (back-to-back streams, no IDLE bubble).
    - Otherwise: state -> IDLE.
  - out_valid deasserts the cycle after the handshake.
  - out_value retains its last value until the next completion.
- Arithmetic:
  - ones_count <= bit_count <= LENGTH always, so no overflow.
  - All counters are unsigned COUNT_WIDTH.
  - LENGTH=1 is legal: one accepted bit completes the stream.

Optional Feature:
- Macro: UNARY_BOUNDS_OUT_EN.
- Defined:
  - Ports lower_bound and upper_bound exist, registered and updated on the same edge as the counters.
  - lower_bound = ones_count.
  - upper_bound = ones_count + (LENGTH - bit_count).
  - IDLE after reset: 0 and LENGTH.
  - After start: 0 and LENGTH.
  - In HOLD: both equal out_value.
  - Invariant: lower_bound <= upper_bound <= LENGTH.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- LENGTH=32, start, 32 consecutive valid bits all 1 -> out_valid=1 exactly one cycle after the 32nd bit accepted, out_value=32.
- start, alternating 1/0 bits with in_valid low every third cycle (gaps) -> out_value=16; in_ready=1 throughout COLLECT.
- Complete a stream of value 7, hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_value stays 7, in_ready=0, counters unchanged; then out_ready=1 -> out_valid=0 next cycle, state IDLE.
- In HOLD assert out_ready=1 and start=1 together, then feed 32 zeros -> busy=1 the next cycle, second out_value=0, no IDLE cycle between streams.
- Mid-stream (after 20 bits), pulse reset=1 for one cycle -> out_valid=0, busy=0, out_value=0. Separately, start=1 mid-stream: the next 32 bits alone determine the result.
- UNARY_BOUNDS_OUT_EN: after 10 accepted bits containing 4 ones -> lower_bound=4, upper_bound=26. At completion with value 13 -> both equal 13.
